// File: rtl/sr_fifo_pkg.sv
// Shared definitions for the FIFO write-arbiter/sequencer and its attached fifo.
// Both sides take their default widths from here so they cannot drift apart.
package sr_fifo_pkg;

    localparam int SR_FIFO_DATA_WIDTH = 32;
    localparam int SR_FIFO_ADDR_WIDTH = 3;
    localparam int SR_FIFO_N_REQ      = 4;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    function automatic int sr_fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sr_fifo_ctrl_if.sv
// Producer/consumer handshake plus the controller-driven fifo controls and status.
// slave = controller side, master = the environment driving producers and the consumer.
interface sr_fifo_ctrl_if
    import sr_fifo_pkg::*;
#(
    parameter int N_REQ      = SR_FIFO_N_REQ,
    parameter int DATA_WIDTH = SR_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = SR_FIFO_ADDR_WIDTH
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        pop_req;
    logic                        pop_ack;
    logic                        rd_valid;
    logic                        fifo_write_enable;
    logic [DATA_WIDTH-1:0]       fifo_write_data;
    logic                        fifo_read_enable;
    logic [ADDR_WIDTH:0]         level;
    logic                        full;
    logic                        empty;

    modport master (
        output req_valid, req_data, pop_req,
        input  req_ready, pop_ack, rd_valid,
        input  fifo_write_enable, fifo_write_data, fifo_read_enable,
        input  level, full, empty
    );

    modport slave (
        input  req_valid, req_data, pop_req,
        output req_ready, pop_ack, rd_valid,
        output fifo_write_enable, fifo_write_data, fifo_read_enable,
        output level, full, empty
    );

endinterface

// File: rtl/fifo.sv
// Plain single-port-pair FIFO storage: no flags, registered read data.
// A simultaneous read+write is dropped entirely; the controller never issues one.
module fifo
    import sr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SR_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = SR_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  read_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_o
);

    localparam int DEPTH = sr_fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  do_write;
    logic                  do_read;

    assign do_write    = write_enable_i && !read_enable_i;
    assign do_read     = read_enable_i && !write_enable_i;
    assign read_data_o = read_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            read_data_q <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                read_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage carries no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= write_data_i;
        end
    end

endmodule

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin picker: scans last_idx+1, last_idx+2, ... modulo N
// and grants the first requester found.
module sr_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_idx_i) + k) % N;
            if (!any_o && req_i[idx[IDX_W-1:0]]) begin
                any_o                  = 1'b1;
                gnt_o[idx[IDX_W-1:0]]  = 1'b1;
                gnt_idx_o              = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sr_fifo_ctrl.sv
// Sole driver of the fifo enables: round-robin write arbitration, read/write
// alternation under contention, and registered occupancy with full/empty.
module sr_fifo_ctrl
    import sr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SR_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = SR_FIFO_ADDR_WIDTH,
    parameter int N_REQ      = SR_FIFO_N_REQ
) (
    input  logic          clk,
    input  logic          rst_n,
    sr_fifo_ctrl_if.slave bus
);

    localparam int                  IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int                  DEPTH     = sr_fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] level_q,    level_d;
    logic                full_q,     full_d;
    logic                empty_q,    empty_d;
    logic                rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
    op_e                 last_op_q,  last_op_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                wr_cand;
    logic                rd_cand;
    logic                do_wr;
    logic                do_rd;

    sr_rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i      (bus.req_valid),
        .last_idx_i (rr_ptr_q),
        .gnt_o      (arb_gnt),
        .gnt_idx_o  (arb_idx),
        .any_o      (arb_any)
    );

    // Op select. last_op only flips when both sides compete, so a lone
    // requester never steals the other side's turn at the next tie.
    always_comb begin
        wr_cand   = arb_any && !full_q;
        rd_cand   = bus.pop_req && !empty_q;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        last_op_d = last_op_q;
        if (rst_n) begin
            if (wr_cand && rd_cand) begin
                if (last_op_q == OP_READ) begin
                    do_wr     = 1'b1;
                    last_op_d = OP_WRITE;
                end else begin
                    do_rd     = 1'b1;
                    last_op_d = OP_READ;
                end
            end else begin
                do_wr = wr_cand;
                do_rd = rd_cand;
            end
        end
    end

    always_comb begin
        level_d    = level_q;
        rr_ptr_d   = rr_ptr_q;
        rd_valid_d = do_rd;
        if (do_wr) begin
            level_d  = level_q + LEVEL_ONE;
            rr_ptr_d = arb_idx;
        end else if (do_rd) begin
            level_d  = level_q - LEVEL_ONE;
        end
        full_d  = (level_d == LEVEL_MAX);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rr_ptr_q   <= IDX_W'(N_REQ - 1);
            last_op_q  <= OP_READ;
        end else begin
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
            rr_ptr_q   <= rr_ptr_d;
            last_op_q  <= last_op_d;
        end
    end

    assign bus.req_ready         = do_wr ? arb_gnt : '0;
    assign bus.pop_ack           = do_rd;
    assign bus.fifo_write_enable = do_wr;
    assign bus.fifo_read_enable  = do_rd;
    assign bus.fifo_write_data   = do_wr ? bus.req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH]
                                         : '0;
    assign bus.rd_valid          = rd_valid_q;
    assign bus.level             = level_q;
    assign bus.full              = full_q;
    assign bus.empty             = empty_q;

endmodule

// File: tb/tb_sr_fifo_ctrl.sv
// Scoreboard bench for sr_fifo_ctrl with the fifo attached: stimulus queues the
// expected grants/read data, a negedge monitor compares whatever the DUT presents.
module tb_sr_fifo_ctrl;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 3;

    typedef struct {
        bit          wr;
        int          idx;
        logic [31:0] data;
        int          cyc;
    } op_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_data;
    int          cyc_n = 0;
    int          checks = 0;
    int          failures = 0;
    op_t         exp_op[$];
    rd_t         exp_rd[$];

    sr_fifo_ctrl_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sr_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_enable_i (bus.fifo_write_enable),
        .write_data_i   (bus.fifo_write_data),
        .read_enable_i  (bus.fifo_read_enable),
        .read_data_o    (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int p, input logic [31:0] d);
        bus.req_data[p*DW +: DW] = d;
    endtask

    task automatic exp_w(input int p, input logic [31:0] d);
        exp_op.push_back('{wr: 1'b1, idx: p, data: d, cyc: cyc_n});
    endtask

    task automatic exp_r(input logic [31:0] d, input bit data_follows);
        exp_op.push_back('{wr: 1'b0, idx: 0, data: 32'h0, cyc: cyc_n});
        if (data_follows) exp_rd.push_back('{data: d, cyc: cyc_n + 1});
    endtask

    // Monitor: every op or read-data beat the DUT shows must match the head of its queue.
    always @(negedge clk) begin
        op_t         e;
        rd_t         r;
        logic [38:0] got;
        logic [38:0] want;
        logic [3:0]  rdy;
        if (rst_n) begin
            chk("en_excl", {62'h0, bus.fifo_write_enable, bus.fifo_read_enable} == 64'h3, 64'h0);
        end
        if (bus.fifo_write_enable || bus.fifo_read_enable || bus.pop_ack || bus.req_ready != '0) begin
            if (exp_op.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_op we=%0b re=%0b ack=%0b rdy=%0h (cycle %0d)",
                         bus.fifo_write_enable, bus.fifo_read_enable, bus.pop_ack,
                         bus.req_ready, cyc_n);
            end else begin
                e    = exp_op.pop_front();
                rdy  = e.wr ? (4'b0001 << e.idx) : 4'b0000;
                got  = {bus.fifo_write_enable, bus.fifo_read_enable, bus.pop_ack,
                        bus.req_ready, bus.fifo_write_data};
                want = {e.wr, !e.wr, !e.wr, rdy, e.wr ? e.data : 32'h0};
                chk(e.wr ? "write_grant" : "read_grant", got, want);
                chk("op_cycle", cyc_n, e.cyc);
            end
        end
        if (bus.rd_valid) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid data=%0h (cycle %0d)", rd_data, cyc_n);
            end else begin
                r = exp_rd.pop_front();
                chk("rd_data", rd_data, r.data);
                chk("rd_cycle", cyc_n, r.cyc);
            end
        end
    end

    initial begin
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.pop_req   = 1'b1;
        for (int i = 0; i < NR; i++) set_data(i, 32'h10 + i);

        // Reset: all requests present, nothing may be granted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_comb_out", {bus.req_ready, bus.pop_ack, bus.fifo_write_enable,
                             bus.fifo_read_enable, bus.fifo_write_data}, 0);
        tick();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.pop_req   = 1'b0;

        // Round robin with all four valid: 0,1,2,3,0.
        bus.req_valid = 4'hF;
        exp_w(0, 32'h10); tick();
        exp_w(1, 32'h11); tick();
        exp_w(2, 32'h12); tick();
        exp_w(3, 32'h13); tick();
        exp_w(0, 32'h10); tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rr_level", bus.level, 5);
        #1 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Fill from producer 2, then a 9th push stalls for 5 cycles.
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            set_data(2, 32'hA0 + k);
            exp_w(2, 32'hA0 + k);
            tick();
        end
        set_data(2, 32'hA8);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_level", bus.level, 8);
            chk("stall_full", bus.full, 1);
            chk("stall_ready", bus.req_ready, 0);
            tick();
        end
        bus.req_valid = '0;

        // Drain 8, then a further pop gets no ack.
        bus.pop_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_r(32'hA0 + k, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("drain_empty", bus.empty, 1);
        chk("drain_level", bus.level, 0);
        chk("drain_no_ack", bus.pop_ack, 0);
        tick();
        bus.pop_req = 1'b0;

        // Bring level to 4 via producer 0, leaving rr_ptr = 0.
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 32'hB0 + k);
            exp_w(0, 32'hB0 + k);
            tick();
        end
        // Contention: producers 1 and 3 against a held pop -> W1,R,W3,R,W1,R.
        set_data(1, 32'hC1);
        set_data(3, 32'hC3);
        bus.req_valid = 4'b1010;
        bus.pop_req   = 1'b1;
        exp_w(1, 32'hC1);        tick();
        exp_r(32'hB0, 1'b1);     tick();
        exp_w(3, 32'hC3);        tick();
        exp_r(32'hB1, 1'b1);     tick();
        exp_w(1, 32'hC1);        tick();
        exp_r(32'hB2, 1'b1);     tick();
        bus.req_valid = '0;
        bus.pop_req   = 1'b0;
        @(negedge clk);
        chk("cont_level", bus.level, 4);
        tick();

        // One more write (level 5), then reset while a pop is in flight.
        set_data(2, 32'hD2);
        bus.req_valid = 4'b0100;
        exp_w(2, 32'hD2);
        tick();
        bus.req_valid = '0;
        bus.pop_req   = 1'b1;
        exp_r(32'hB3, 1'b0);
        @(negedge clk);
        chk("pre_rst_level", bus.level, 5);
        #1 rst_n = 1'b0;
        tick();
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_rd_valid", bus.rd_valid, 0);
        chk("mid_rst_empty", bus.empty, 1);
        bus.pop_req = 1'b0;
        tick();
        rst_n = 1'b1;

        // First grant after release goes to producer 0.
        set_data(0, 32'hD0);
        set_data(2, 32'hD2);
        set_data(3, 32'hD3);
        bus.req_valid = 4'b1101;
        exp_w(0, 32'hD0);
        tick();

        // Sparse: producer 3 alone for 4 cycles, then 0 and 3 -> scan wraps to 0.
        set_data(3, 32'hE3);
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            exp_w(3, 32'hE3);
            tick();
        end
        set_data(0, 32'hE0);
        bus.req_valid = 4'b1001;
        exp_w(0, 32'hE0);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("sparse_level", bus.level, 6);
        tick();

        bus.pop_req = 1'b1;
        exp_r(32'hD0, 1'b1); tick();
        for (int k = 0; k < 4; k++) begin
            exp_r(32'hE3, 1'b1);
            tick();
        end
        exp_r(32'hE0, 1'b1); tick();
        bus.pop_req = 1'b0;
        @(negedge clk);
        chk("final_level", bus.level, 0);
        chk("final_empty", bus.empty, 1);
        tick(); tick();

        chk("op_queue_left", exp_op.size(), 0);
        chk("rd_queue_left", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
